// File: rtl/decrypt_stream.sv
// Two-stage streaming nibble-cipher decryptor: 1 cycle from accept to out_valid, 1 byte/cycle.
// Backpressure: a stage advances only when the stage after it is empty or draining; in_ready is combinational from out_ready.
module decrypt_stream #(
    parameter int COUNT_W = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_key_load,
    input  logic [7:0]         i_key_in,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [7:0]         i_in_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [7:0]         o_out_data,
    output logic               o_busy,
    output logic [COUNT_W-1:0] o_byte_count
);

    logic [7:0]         r_key;
    logic               r_s1_vld;
    logic [7:0]         r_s1_c;
    logic [7:0]         r_s1_x;
    logic               r_s1_k0;
    logic               r_s2_vld;
    logic [7:0]         r_s2_dat;
    logic [COUNT_W-1:0] r_count;

    logic               w_a1;
    logic               w_a2;
    logic               w_accept;
    logic               w_deliver;
    logic [7:0]         w_e;
    logic [7:0]         w_x;
    logic [3:0]         w_s;
    logic [7:0]         w_p;

    assign w_a2      = !r_s2_vld || i_out_ready;
    assign w_a1      = !r_s1_vld || w_a2;
    assign w_accept  = i_in_valid && w_a1;
    assign w_deliver = r_s2_vld && i_out_ready;

    // The lower nibble travels in the clear, so the mask is rebuilt from it and the key.
    assign w_e = {i_in_data[3], i_in_data[0], i_in_data[1], i_in_data[2],
                  i_in_data[1], i_in_data[3], i_in_data[2], i_in_data[0]};
    assign w_x = w_e ^ r_key;
    assign w_s = r_s1_x[7:4] + r_s1_x[3:0] + {3'b000, r_s1_k0};
    assign w_p = {r_s1_c[7:4] ^ w_s, r_s1_c[3:0]};

    // Stage 1 latches the key-derived material so later key loads cannot touch in-flight bytes.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_key    <= 8'h00;
            r_s1_vld <= 1'b0;
            r_s1_c   <= 8'h00;
            r_s1_x   <= 8'h00;
            r_s1_k0  <= 1'b0;
        end else begin
            if (i_key_load) begin
                r_key <= i_key_in;
            end
            if (w_a1) begin
                r_s1_vld <= w_accept;
            end
            if (w_accept) begin
                r_s1_c  <= i_in_data;
                r_s1_x  <= w_x;
                r_s1_k0 <= r_key[0];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s2_vld <= 1'b0;
            r_s2_dat <= 8'h00;
            r_count  <= '0;
        end else begin
            if (w_a2) begin
                r_s2_vld <= r_s1_vld;
            end
            if (w_a2 && r_s1_vld) begin
                r_s2_dat <= w_p;
            end
            if (w_deliver) begin
                r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_in_ready   = w_a1;
    assign o_out_valid  = r_s2_vld;
    assign o_out_data   = r_s2_dat;
    assign o_busy       = r_s1_vld || r_s2_vld;
    assign o_byte_count = r_count;

endmodule

// File: tb/tb_decrypt_stream.sv
// Bench for decrypt_stream: directed vectors plus randomized traffic scored against a queue-based cipher model.
module tb_decrypt_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_load = 1'b0;
    logic [7:0]  key_in = 8'h00;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        busy;
    logic [15:0] byte_count;
    logic        w4_in_ready;
    logic        w4_out_valid;
    logic [7:0]  w4_out_data;
    logic        w4_busy;
    logic [3:0]  byte_count4;

    decrypt_stream #(.COUNT_W(16)) dut (
        .i_clock(clk), .i_reset(rst), .i_key_load(key_load), .i_key_in(key_in),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_busy(busy), .o_byte_count(byte_count)
    );

    decrypt_stream #(.COUNT_W(4)) dut4 (
        .i_clock(clk), .i_reset(rst), .i_key_load(key_load), .i_key_in(key_in),
        .i_in_valid(in_valid), .o_in_ready(w4_in_ready), .i_in_data(in_data),
        .o_out_valid(w4_out_valid), .i_out_ready(out_ready), .o_out_data(w4_out_data),
        .o_busy(w4_busy), .o_byte_count(byte_count4)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mkey = 8'h00;
    int         nh = 0;
    logic [7:0] tx[256];

    // Mask the encryptor applied to the upper nibble, derived from the clear lower nibble.
    function automatic logic [3:0] mask_of(input logic [3:0] lo, input logic [7:0] k);
        logic [7:0] e;
        logic [7:0] x;
        int         s;
        e = {lo[3], lo[0], lo[1], lo[2], lo[1], lo[3], lo[2], lo[0]};
        x = e ^ k;
        s = (int'(x[7:4]) + int'(x[3:0]) + int'(k[0])) % 16;
        return 4'(s);
    endfunction

    function automatic logic [7:0] dec_model(input logic [7:0] c, input logic [7:0] k);
        return {c[7:4] ^ mask_of(c[3:0], k), c[3:0]};
    endfunction

    function automatic logic [7:0] enc_model(input logic [7:0] p, input logic [7:0] k);
        return {p[7:4] ^ mask_of(p[3:0], k), p[3:0]};
    endfunction

    // Inputs are stable from posedge+1 to the next posedge, so the negedge view predicts each edge.
    always @(negedge clk) begin
        if (rst) begin
            got_q.delete();
            exp_q.delete();
            mkey = 8'h00;
            nh   = 0;
        end else begin
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                nh++;
            end
            if (in_valid && in_ready) exp_q.push_back(dec_model(in_data, mkey));
            if (key_load) mkey = key_in;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; key_load = 1'b0; out_ready = 1'b0;
        tick;
        rst = 1'b0;
    endtask

    task automatic load_key(input logic [7:0] k);
        key_load = 1'b1; key_in = k;
        tick;
        key_load = 1'b0;
    endtask

    task automatic drive_tx(input int n, output int sent);
        int   idx;
        logic acc;
        idx = 0;
        in_valid = 1'b1; in_data = tx[0];
        for (int cyc = 0; cyc < n * 4 + 20 && idx < n; cyc++) begin
            @(negedge clk);
            acc = in_ready;
            tick;
            if (acc) begin
                idx++;
                if (idx < n) in_data = tx[idx];
            end
        end
        in_valid = 1'b0;
        sent = idx;
    endtask

    task automatic wait_got(input int n, output bit ok);
        for (int cyc = 0; cyc < 400 && got_q.size() < n; cyc++) tick;
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset;
        do_reset;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        n_tests++; if (byte_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", byte_count); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick;
    endtask

    task automatic test_single;
        load_key(8'h93);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h06;
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_stage1: got valid=%b busy=%b want 0/1", out_valid, busy); end
        tick;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h46) begin n_fail++; $display("FAIL single_out: got valid=%b data=%h want 1/46", out_valid, out_data); end
        tick;
        @(negedge clk);
        n_tests++; if (byte_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", byte_count); end
        n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got busy=%b valid=%b want 0/0", busy, out_valid); end
        n_tests++; if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL single_model: got %0d bytes want 1 matching model", got_q.size()); end
        tick;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        load_key(8'hAC);
        in_valid = 1'b1; in_data = 8'h39; key_load = 1'b1; key_in = 8'h5A;
        tick;
        key_load = 1'b0; in_data = 8'h35;
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 8'hC9) begin n_fail++; $display("FAIL b2b_first: got valid=%b data=%h want 1/c9", out_valid, out_data); end
        tick;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_fail++; $display("FAIL b2b_second: got valid=%b data=%h want 1/a5", out_valid, out_data); end
        tick;
        @(negedge clk);
        n_tests++; if (byte_count !== 16'd3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", byte_count); end
        tick;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure;
        int   idx;
        logic acc;
        bit   ok;
        do_reset;
        load_key(8'($urandom));
        for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
        idx = 0; in_valid = 1'b1; in_data = tx[0]; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && (idx < 4 || got_q.size() < 4); cyc++) begin
            if (cyc == 1) out_ready = 1'b0;
            if (cyc == 10) out_ready = 1'b1;
            @(negedge clk);
            if (cyc == 3 || cyc == 8) begin
                n_tests++; if (in_ready !== 1'b0 || busy !== 1'b1 || idx != 2) begin n_fail++; $display("FAIL bp_full: got in_ready=%b busy=%b held=%0d want 0/1/2", in_ready, busy, idx); end
                n_tests++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_hold: got valid=%b data=%h want 1/%h", out_valid, out_data, exp_q[0]); end
            end
            acc = in_valid && in_ready;
            tick;
            if (acc) begin
                idx++;
                if (idx < 4) in_data = tx[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        ok = (idx == 4 && got_q.size() == 4 && exp_q.size() == 4);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got sent=%0d delivered=%0d want 4/4", idx, got_q.size()); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        @(negedge clk);
        n_tests++; if (byte_count !== 16'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", byte_count); end
        tick;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random;
        bit ok;
        do_reset;
        for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            key_load  = ($urandom_range(0, 3) == 0);
            key_in    = 8'($urandom);
            tick;
        end
        in_valid = 1'b0; key_load = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got_q.size() < exp_q.size(); cyc++) tick;
        ok = (got_q.size() == exp_q.size() && exp_q.size() > 0);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_count: got %0d delivered want %0d", got_q.size(), exp_q.size()); end
        if (ok) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        @(negedge clk);
        n_tests++; if (byte_count !== 16'(nh)) begin n_fail++; $display("FAIL rand_byte_count: got %0d want %0d", byte_count, nh); end
        tick;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_sweep;
        int         sent;
        bit         ok;
        logic [7:0] c;
        do_reset;
        load_key(8'hB1);
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) tx[i] = 8'(i);
        drive_tx(256, sent);
        wait_got(256, ok);
        n_tests++; if (sent != 256 || !ok) begin n_fail++; $display("FAIL sweep_timeout: got sent=%0d delivered=%0d want 256/256", sent, got_q.size()); end
        if (ok) begin
            for (int i = 0; i < 256; i++) begin
                c = 8'(i);
                n_tests++; if (got_q[i] !== dec_model(c, 8'hB1)) begin n_fail++; $display("FAIL sweep_dec[%0d]: got %h want %h", i, got_q[i], dec_model(c, 8'hB1)); end
                n_tests++; if (enc_model(got_q[i], 8'hB1) !== c) begin n_fail++; $display("FAIL sweep_roundtrip[%0d]: got %h want %h", i, enc_model(got_q[i], 8'hB1), c); end
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid;
        int sent;
        bit ok;
        load_key(8'($urandom));
        out_ready = 1'b0;
        tx[0] = 8'($urandom); tx[1] = 8'($urandom);
        drive_tx(2, sent);
        @(negedge clk);
        n_tests++; if (sent != 2 || busy !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_loaded: got sent=%0d busy=%b valid=%b want 2/1/1", sent, busy, out_valid); end
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_flush: got valid=%b busy=%b want 0/0", out_valid, busy); end
        n_tests++; if (byte_count !== 16'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_state: got count=%0d in_ready=%b want 0/1", byte_count, in_ready); end
        tick;
        out_ready = 1'b1;
        tx[0] = 8'h06;
        drive_tx(1, sent);
        wait_got(1, ok);
        n_tests++; if (!ok || got_q[0] !== 8'hD6 || got_q[0] !== dec_model(8'h06, 8'h00)) begin n_fail++; $display("FAIL rmid_zero_key: got %0d bytes first=%h want d6", got_q.size(), ok ? got_q[0] : 8'h00); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap;
        int   idx;
        int   last_nh;
        int   n_chk;
        logic acc;
        bit   ok;
        do_reset;
        load_key(8'($urandom));
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) tx[i] = 8'($urandom);
        idx = 0; last_nh = 0; n_chk = 0;
        in_valid = 1'b1; in_data = tx[0];
        for (int cyc = 0; cyc < 80 && nh < 17; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick;
            if (acc) begin
                idx++;
                if (idx < 17) in_data = tx[idx];
                else in_valid = 1'b0;
            end
            if (nh >= 15 && nh != last_nh) begin
                n_chk++;
                n_tests++; if (byte_count4 !== 4'(nh % 16)) begin n_fail++; $display("FAIL wrap_count@%0d: got %0d want %0d", nh, byte_count4, nh % 16); end
            end
            last_nh = nh;
        end
        in_valid = 1'b0;
        n_tests++; if (n_chk != 3) begin n_fail++; $display("FAIL wrap_timeout: got %0d wrap checks want 3", n_chk); end
        @(negedge clk);
        n_tests++; if (byte_count !== 16'd17) begin n_fail++; $display("FAIL wrap_wide_count: got %0d want 17", byte_count); end
        ok = (got_q.size() == 17 && exp_q.size() == 17);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_bytes: got %0d want 17", got_q.size()); end
        if (ok) begin
            for (int i = 0; i < 17; i++) begin
                n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        tick;
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_random;
        test_sweep;
        test_reset_mid;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decrypt_stream.md
# decrypt_stream

Streaming decryptor that inverts the 8-bit nibble cipher produced by the encryption block: it recovers plaintext bytes from ciphertext bytes under the same 8-bit key. It sits on the receive side of the link as a 2-stage pipeline with valid/ready handshakes on input and output, a loadable key register, and a delivered-byte counter.

## Interface
- COUNT_W, 16, width of the delivered-byte counter
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- key_load  input  1  load key_in into the key register at this edge
- key_in  input  8  new key value
- in_valid  input  1  in_data holds a ciphertext byte
- in_ready  output  1  block can accept a byte this cycle
- in_data  input  8  ciphertext byte c
- out_valid  output  1  out_data holds a plaintext byte
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  8  plaintext byte p
- busy  output  1  at least one pipeline stage holds a byte
- byte_count  output  COUNT_W  number of output handshakes since reset, modulo 2^COUNT_W

## Operation
- Cipher inverse, for ciphertext c and key k:
  - e = {c[3], c[0], c[1], c[2], c[1], c[3], c[2], c[0]} (bit 7 down to bit 0)
  - x = e ^ k
  - s = (x[7:4] + x[3:0] + k[0]) mod 16; the carry-out is discarded
  - p = {c[7:4] ^ s, c[3:0]}
- Lower nibble passes through unchanged; only the upper nibble is unmasked.
- Stage 1 (S1): on accept (in_valid & in_ready), capture c, x, and k[0] computed with the current key register. S1 valid flag set.
- Stage 2 (S2): when S1 advances, capture p. S2 valid flag drives out_valid; the S2 data register drives out_data.
- Key register: loaded from key_in at any edge where key_load=1. A byte accepted at that same edge uses the OLD key. In-flight bytes carry their own derived key material and are not affected by later key loads.
- Flow control:
  - S2 advance enable a2 = !s2_valid | out_ready.
  - S1 advance enable a1 = !s1_valid | a2.
  - in_ready = a1. in_ready is combinational from out_ready.
  - On an edge with out_ready=1 and s2_valid=1 and no S1 advance, S2 empties.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- byte_count increments by 1 on each out_valid & out_ready edge and wraps from all-ones to 0.
- busy = s1_valid | s2_valid.

## Timing
- Reset values: out_valid=0, out_data=0x00, byte_count=0, busy=0, key register=0x00, both stage valid flags=0. in_ready=1 in the first cycle after reset.
- Latency: a byte accepted at edge N is presented with out_valid=1 after edge N+1.
- Throughput: 1 byte/cycle while out_ready=1.
- Full condition: both stages valid and out_ready=0 forces in_ready=0. Exactly 2 bytes are buffered. No byte is dropped or duplicated.
- Simultaneous accept and output on the same edge: both take effect, and the pipeline stays full.
- Reset asserted mid-stream: all in-flight bytes are discarded at that edge, the counter clears, and the key returns to 0x00. reset has priority over key_load and over any handshake.

## Test plan
- Single byte, key 0x93: load key, send 0x06 with out_ready=1 -> out_data=0x46 and out_valid=1 two edges after key_load+accept sequence; byte_count=1.
- Back-to-back stream with per-byte key: (0x39, key 0xAC) -> 0xC9; (0x35, key 0x5A) -> 0xA5. Issue key_load on the same edge as the previous byte's accept -> the previous byte still decrypts with the old key.
- Backpressure: stream 4 bytes, hold out_ready=0 after the first -> in_ready=0 once 2 bytes are held. out_data stays stable. Releasing out_ready delivers all 4 in order with no loss; byte_count=4.
- Round-trip sweep: for all 256 c with key 0xB1, compare against a reference model of the inverse -> all match. Re-encrypting each p must give back c.
- Reset mid-operation: with 2 bytes in flight, pulse reset -> next cycle out_valid=0, busy=0, byte_count=0, in_ready=1. Then 0x06 with key 0x00 -> 0x06 ^ {s,0}, checked against the model.
- Counter wrap: with COUNT_W=4, deliver 17 bytes -> byte_count reads 15, 0, 1 on the last three handshakes.
